// File: rtl/song_pkg.sv
// ---------------------------------------------------------------------------
// song_pkg : shared widths, rest code and timer state encoding
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package song_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } timer_state_e;

endpackage

`default_nettype wire

// File: rtl/beat_timer.sv
// ---------------------------------------------------------------------------
// beat_timer : counts a loaded number of beat ticks down, then pulses done
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module beat_timer
  import song_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] dur,
  input  logic             tick,
  output logic             done,
  output logic             busy
);

  timer_state_e     state_q;
  logic [DUR_W-1:0] count_q;
  logic             done_q;

  // A load always wins over a coincident tick; a zero duration expires at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        if (dur == '0) begin
          state_q <= IDLE;
          count_q <= '0;
          done_q  <= 1'b1;
        end else begin
          state_q <= BUSY;
          count_q <= dur;
        end
      end else if ((state_q == BUSY) && tick) begin
        if (count_q == DUR_W'(1)) begin
          state_q <= IDLE;
          count_q <= '0;
          done_q  <= 1'b1;
        end else begin
          count_q <= count_q - 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign busy = (state_q == BUSY);

endmodule

`default_nettype wire

// File: rtl/note_player.sv
// ---------------------------------------------------------------------------
// note_player : three-voice note hold timers, advance timer and beat prescaler
// Rev 1.0     : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module note_player
  import song_pkg::*;
#(
  parameter int BEAT_DIV = 1000,
  parameter int BEAT_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              new_note_one,
  input  logic              new_note_two,
  input  logic              new_note_three,
  input  logic [NOTE_W-1:0] note_one,
  input  logic [NOTE_W-1:0] note_two,
  input  logic [NOTE_W-1:0] note_three,
  input  logic [DUR_W-1:0]  duration_one,
  input  logic [DUR_W-1:0]  duration_two,
  input  logic [DUR_W-1:0]  duration_three,
  input  logic              advance_load,
  input  logic [DUR_W-1:0]  advance_duration,
  output logic              beat,
  output logic              note_one_done,
  output logic              note_two_done,
  output logic              note_three_done,
  output logic              advance_done,
  output logic [NOTE_W-1:0] active_note_one,
  output logic [NOTE_W-1:0] active_note_two,
  output logic [NOTE_W-1:0] active_note_three,
  output logic              voice_on_one,
  output logic              voice_on_two,
  output logic              voice_on_three
);

  localparam logic [BEAT_W-1:0] C_BEAT_LAST = BEAT_W'(BEAT_DIV - 1);

  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic              beat_q, beat_d;
  logic              w_tick;

  always_comb begin
    cnt_d  = cnt_q;
    beat_d = 1'b0;
    if (play) begin
      if (cnt_q == C_BEAT_LAST) begin
        cnt_d  = '0;
        beat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      beat_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
    end
  end

  // Gating with play keeps a beat that straddles a pause from moving timers.
  assign beat   = beat_q;
  assign w_tick = beat_q & play;

  logic              w_load [3];
  logic [NOTE_W-1:0] w_note [3];
  logic [DUR_W-1:0]  w_dur  [3];
  logic              w_done [3];
  logic              w_busy [3];
  logic [NOTE_W-1:0] note_q [3];

  assign w_load[0] = new_note_one;
  assign w_load[1] = new_note_two;
  assign w_load[2] = new_note_three;
  assign w_note[0] = note_one;
  assign w_note[1] = note_two;
  assign w_note[2] = note_three;
  assign w_dur[0]  = duration_one;
  assign w_dur[1]  = duration_two;
  assign w_dur[2]  = duration_three;

  generate
    for (genvar v = 0; v < 3; v++) begin : g_voice
      beat_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_load[v]),
        .dur   (w_dur[v]),
        .tick  (w_tick),
        .done  (w_done[v]),
        .busy  (w_busy[v])
      );

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          note_q[v] <= NOTE_REST;
        end else if (w_load[v]) begin
          note_q[v] <= w_note[v];
        end
      end
    end
  endgenerate

  logic w_adv_busy_unused;

  beat_timer u_advance (
    .clk   (clk),
    .reset (reset),
    .load  (advance_load),
    .dur   (advance_duration),
    .tick  (w_tick),
    .done  (advance_done),
    .busy  (w_adv_busy_unused)
  );

  // The latched note is only exposed while its timer is running.
  assign active_note_one   = w_busy[0] ? note_q[0] : NOTE_REST;
  assign active_note_two   = w_busy[1] ? note_q[1] : NOTE_REST;
  assign active_note_three = w_busy[2] ? note_q[2] : NOTE_REST;

  assign voice_on_one   = w_busy[0] && (note_q[0] != NOTE_REST);
  assign voice_on_two   = w_busy[1] && (note_q[1] != NOTE_REST);
  assign voice_on_three = w_busy[2] && (note_q[2] != NOTE_REST);

  assign note_one_done   = w_done[0];
  assign note_two_done   = w_done[1];
  assign note_three_done = w_done[2];

endmodule

`default_nettype wire
